fixed_power: RTL and testbench
==============================

# fixed_power

Sequential fixed-point power unit, the inverse of the root block. It raises a Q10.10 base to a small integer exponent, `out = base^n`, by repeated multiply. It sits beside the root unit in the division/root datapath and is used for round-trip checking, where `root(x, n)^n ≈ x`. It reuses the same `in_valid`/`out_valid` single-pulse protocol and the same Q10.10 result format.

## Interface
- `FRAC`, default 10: fractional bits of the Q format. The block is verified only at 10.
- `W`, default 20: total data width. The block is verified only at 20.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: one-cycle request strobe. Sampled only when `busy`=0.
- `in_data_1`  in  20: base, unsigned Q10.10.
- `in_data_2`  in  3: exponent n, range 0..7.
- `busy`  out  1: a request is in flight.
- `out_valid`  out  1: one-cycle result strobe.
- `out_data`  out  20: result, unsigned Q10.10. Zero whenever `out_valid`=0.
- `out_ovf`  out  1: result saturated. Valid only with `out_valid`; 0 otherwise.

## Operation
- **States:**
  - IDLE: waits for a request.
  - MUL: performs one multiply per cycle.
  - DONE: presents the result for one cycle.
- **IDLE**, when `in_valid`=1:
  - Latch base into `base_r` and n into `exp_r`.
  - Set `acc` = 20'h00400 (1.0), `cnt` = 0, `ovf` = 0.
  - Go to MUL if n>0, otherwise go to DONE.
- **MUL**, each cycle:
  - `prod[39:0] = acc * base_r`; `cnt` = `cnt`+1.
  - If `ovf`=1, or `prod[39:30]` != 0: set `acc` = 20'hFFFFF and set `ovf`=1. Saturation is sticky; later multiplies never lower it.
  - Otherwise `acc` = `prod[29:10]`, i.e. truncation toward zero with no rounding.
  - When the new `cnt` equals `exp_r`, go to DONE.
- **DONE:** `out_valid`=1, `out_data`=`acc`, `out_ovf`=`ovf` for exactly one cycle, then go to IDLE.
- **Busy:** `busy`=1 in MUL and DONE, 0 in IDLE.
- **Ignored requests:** `in_valid` asserted while `busy`=1 is dropped with no side effect. Latched operands are unaffected by input changes after capture.
- **Exponent 0:** result is 1.0 for any base, including 0.
- **Exponent 1:** result equals the base exactly.
- **Zero base:** with n≥1 the result is 0.

## Timing
- **Latency:** a request accepted in cycle T gives `out_valid` in cycle T+n+1.
  - n=0: T+1.
  - n=7: T+8.
- **Busy window:** `busy` is high in cycles T+1..T+n+1. The earliest next accept is cycle T+n+2, giving a throughput of 1 result per n+2 cycles.
- **Outputs:** all are registered, with no combinational path from inputs.
- **Reset values:** state=IDLE, `busy`=0, `out_valid`=0, `out_data`=20'h00000, `out_ovf`=0. Internal `acc`, `cnt`, `ovf` and the latched operands are cleared.
- **Reset during MUL or DONE:** the request is aborted with no `out_valid`. The block returns to IDLE in the next cycle and accepts `in_valid` one cycle after `rst` deasserts.
- **`rst` and `in_valid` in the same cycle:** reset wins and the request is not captured.
- **`in_valid` in the DONE cycle:** ignored, because `busy`=1.

## Test plan
- Base 20'h00800 (2.0), n=3 at cycle T -> `out_valid` only at T+4, `out_data`=20'h02000 (8.0), `out_ovf`=0. `busy` is high at T+1..T+4.
- Base 20'h00600 (1.5), n=2 -> 20'h00900 (2.25). Base 20'h00200 (0.5), n=7 -> 20'h00008. Base 20'h00001, n=2 -> 20'h00000 (truncation).
- Base 20'h12345, n=0 -> 20'h00400 at T+1. Base 20'h12345, n=1 -> 20'h12345 at T+2.
- Base 20'h04000 (16.0), n=3 -> 20'hFFFFF with `out_ovf`=1. Base 20'hFFFFF, n=7 -> 20'hFFFFF with `out_ovf`=1.
- Request base 3.0 (20'h00C00), n=3. Pulse `in_valid` with different data at T+2 and T+4 (the DONE cycle) -> a single result 20'h06C00 (27.0), no second `out_valid`. A new request at T+5 is accepted.
- Assert `rst` at T+2 of an n=5 request -> no `out_valid` ever appears for it, all outputs are 0. A request at the first cycle after `rst` deasserts completes normally.

Source files
------------

// File: rtl/fixed_power.sv
// fixed_power: sequential unsigned Qm.FRAC power unit, out = base^n, computed
// by one truncating multiply per cycle with sticky saturation.
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst        - synchronous active-high reset
//   in_valid   - one-cycle request strobe, sampled only while idle
//   in_data_1  - base, unsigned Q(W-FRAC).FRAC
//   in_data_2  - exponent n, 0..7
//   busy       - request in flight (MUL or DONE)
//   out_valid  - one-cycle result strobe
//   out_data   - result, zero whenever out_valid is low
//   out_ovf    - result saturated, qualified by out_valid
module fixed_power #(
    parameter int unsigned FRAC = 10,
    parameter int unsigned W    = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data_1,
    input  logic [2:0]   in_data_2,
    output logic         busy,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);

    localparam int unsigned EW = 3;
    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic [W-1:0] SAT = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   base_q, base_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [EW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_ovf_q, out_ovf_d;
    logic [PW-1:0]  prod_c;

    // Next-state, datapath and registered-output precompute
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        exp_d       = exp_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        prod_c      = PW'(acc_q) * PW'(base_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d  = in_data_1;
                    exp_d   = in_data_2;
                    acc_d   = ONE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (in_data_2 != '0) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + EW'(1);
                // Any integer bits beyond the Q range, or an earlier overflow,
                // pin the accumulator at full scale.
                if (ovf_q || (prod_c[PW-1:W+FRAC] != '0)) begin
                    acc_d = SAT;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = prod_c[W+FRAC-1:FRAC];
                end
                if (cnt_d == exp_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);
        out_data_d  = (state_d == S_DONE) ? acc_d : '0;
        out_ovf_d   = (state_d == S_DONE) ? ovf_d : 1'b0;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            exp_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_power.sv
// Directed bench for fixed_power: hand-computed Q10.10 power results,
// latency/busy window, ignored requests, saturation and reset abort.
module tb_fixed_power;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        busy;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ovf;

    int n_cmp = 0;
    int n_mis = 0;

    fixed_power #(.FRAC(10), .W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_ovf"}, 32'(out_ovf), 32'd0);
    endtask

    // Issue one request and check every cycle of its busy window, then the
    // first idle cycle afterwards.
    task automatic run(input string tag, input logic [19:0] base, input logic [2:0] n,
                       input logic [19:0] exp_data, input logic exp_ovf);
        in_valid  = 1'b1;
        in_data_1 = base;
        in_data_2 = n;
        tick();
        in_valid  = 1'b0;
        in_data_1 = 20'h0;
        in_data_2 = 3'd0;
        for (int k = 1; k <= int'(n) + 1; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (k == int'(n) + 1) begin
                chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
                chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
            end else begin
                chk({tag, "_novalid"}, 32'(out_valid), 32'd0);
                chk({tag, "_zdata"}, 32'(out_data), 32'd0);
            end
            tick();
        end
        chk_idle_outs({tag, "_after"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data_1 = 20'h0;
        in_data_2 = 3'd0;
        tick();
        tick();
        chk_idle_outs("reset");
        rst = 1'b0;
        tick();
        chk_idle_outs("post_reset");

        // Main function vectors
        run("pow_2_3",     20'h00800, 3'd3, 20'h02000, 1'b0);
        run("pow_1p5_2",   20'h00600, 3'd2, 20'h00900, 1'b0);
        run("pow_0p5_7",   20'h00200, 3'd7, 20'h00008, 1'b0);
        run("trunc",       20'h00001, 3'd2, 20'h00000, 1'b0);
        run("exp0",        20'h12345, 3'd0, 20'h00400, 1'b0);
        run("exp0_zero",   20'h00000, 3'd0, 20'h00400, 1'b0);
        run("exp1",        20'h12345, 3'd1, 20'h12345, 1'b0);
        run("zero_base",   20'h00000, 3'd4, 20'h00000, 1'b0);
        run("sat_16_3",    20'h04000, 3'd3, 20'hFFFFF, 1'b1);
        run("sat_max_7",   20'hFFFFF, 3'd7, 20'hFFFFF, 1'b1);
        run("no_sat_16_2", 20'h04000, 3'd2, 20'h40000, 1'b0);

        // Requests during busy are dropped, including in the DONE cycle
        in_valid  = 1'b1;
        in_data_1 = 20'h00C00;
        in_data_2 = 3'd3;
        tick();                                   // T+1
        in_valid  = 1'b0;
        in_data_1 = 20'h00800;
        in_data_2 = 3'd7;
        tick();                                   // T+2
        in_valid  = 1'b1;
        tick();                                   // T+3
        in_valid  = 1'b0;
        chk("ign_t3_valid", 32'(out_valid), 32'd0);
        tick();                                   // T+4, DONE
        chk("ign_t4_valid", 32'(out_valid), 32'd1);
        chk("ign_t4_data", 32'(out_data), 32'h06C00);
        chk("ign_t4_ovf", 32'(out_ovf), 32'd0);
        in_valid  = 1'b1;
        in_data_1 = 20'h00400;
        in_data_2 = 3'd1;
        tick();                                   // T+5
        in_valid  = 1'b0;
        chk_idle_outs("ign_t5");
        run("ign_next", 20'h00600, 3'd2, 20'h00900, 1'b0);

        // Reset mid-request aborts it; reset beats a coincident in_valid
        in_valid  = 1'b1;
        in_data_1 = 20'h00800;
        in_data_2 = 3'd5;
        tick();                                   // T+1
        in_valid  = 1'b0;
        chk("abort_busy", 32'(busy), 32'd1);
        tick();                                   // T+2
        rst = 1'b1;
        tick();                                   // T+3
        chk_idle_outs("abort_t3");
        in_valid  = 1'b1;
        in_data_1 = 20'h00800;
        in_data_2 = 3'd2;
        tick();                                   // T+4, rst+in_valid not captured
        in_valid  = 1'b0;
        chk_idle_outs("abort_t4");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_quiet_valid", 32'(out_valid), 32'd0);
            chk("abort_quiet_busy", 32'(busy), 32'd0);
        end

        // Request in the first cycle after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run("post_rst_req", 20'h00C00, 3'd2, 20'h02400, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
